modulo_seq: RTL
===============

Name: modulo_seq

Overview:
- Parametrised, fixed-latency radix-2 restoring modulo unit: O = A mod B for WIDTH-bit unsigned operands.
- Generalises the existing 64-bit repeated-subtraction modulo, whose latency depends on the data; this block takes WIDTH+2 cycles for every nonzero B.
- Adds busy and divide-by-zero reporting.
- Sits under the RSA modular-exponentiation datapath, which loads operands with ld and waits for Done.

Parameters:
- WIDTH, 64, operand and result width in bits (>= 2).
- CNT_W, $clog2(WIDTH), width of the iteration counter (derived; do not override).

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous, active-low reset (asserted when 0).
- ld  input  1  start request; sampled only in IDLE.
- A  input  WIDTH  dividend, captured on accepted ld.
- B  input  WIDTH  modulus, captured on accepted ld.
- O  output  WIDTH  remainder; holds until the next Done.
- Done  output  1  one-cycle pulse when O (and Err) are valid.
- Busy  output  1  high from the cycle after an accepted ld until the cycle Done is high (inclusive).
- Err  output  1  set with Done when B == 0; cleared on the next accepted ld.
- Q  output  WIDTH  quotient; present only with MODULO_QUOTIENT_EN.

Behaviour:
- Reset (rst == 0, asynchronous): state = IDLE; O, Q, Done, Busy, Err, internal registers and counter all 0.
- States:
  - IDLE: ld == 1 and B != 0 -> capture a_sh = A and b_r = B; rem = 0; cnt = WIDTH-1; go to RUN.
  - IDLE: ld == 1 and B == 0 -> go to ZERO.
  - IDLE: ld == 0 -> stay in IDLE.
  - RUN, one bit per cycle:
    - t = {rem[WIDTH-1:0], a_sh[WIDTH-1]} (WIDTH+1 bits).
    - If t >= {1'b0, b_r}: rem = t - b_r and the quotient bit is 1; otherwise rem = t and the bit is 0.
    - a_sh shifts left, with the quotient bit entering at the LSB.
    - When cnt == 0, go to FIN; otherwise cnt - 1.
  - FIN: O = rem[WIDTH-1:0]; Q = a_sh; Done = 1; Err = 0; go to IDLE.
  - ZERO: O = A value captured at ld; Q = all ones; Done = 1; Err = 1; go to IDLE.
- Latency, with ld accepted at edge 0:
  - Nonzero B: Done high in the cycle after edge WIDTH+1, i.e. WIDTH+2 cycles after ld.
  - B == 0: Done high 2 cycles after ld.
- Width rules:
  - Remainder is kept as WIDTH+1 bits internally, so a carry-out at the MSB is never lost.
  - After each step rem < b_r.
  - O is truncated to WIDTH bits, which is lossless.
- Handshake:
  - ld while Busy is ignored; operands are not re-sampled.
  - ld held high through the Done cycle is not accepted until the state is back in IDLE, the cycle after Done. It then starts a new operation.
  - A and B may change freely after acceptance.
- Boundaries:
  - A < B -> O = A.
  - A == B -> O = 0.
  - B == 1 -> O = 0.
  - A == 0 -> O = 0.
  - A = B = 2^WIDTH-1 -> O = 0.
- Reset mid-operation: aborts immediately. No Done is produced; outputs clear per the reset values above.
- Done and Err are registered outputs with no combinational path from inputs.

Optional Feature:
- Macro: MODULO_QUOTIENT_EN.
- Defined: the Q port exists and carries A / B (all ones on divide-by-zero), valid when Done is high and held until the next Done.
- Undefined: no Q port and no quotient logic. The shift register still shifts, but its LSB is driven with 0 and synthesis may prune it. Remainder behaviour and latency are identical.

Decomposition:
- Package modulo_pkg:
  - state enum mod_state_t = {IDLE, RUN, FIN, ZERO}, 2 bits.
  - localparam function for the counter width.
- Sub-module mod_sub_stage:
  - Purely combinational conditional subtract, parameter WIDTH.
  - Inputs: t [WIDTH+1], b [WIDTH].
  - Outputs: r [WIDTH+1], qbit.
  - Replaces the old fullsubtractor instance; the top-level FSM instantiates it once.

Test Plan:
- WIDTH=64, A=100, B=7 -> Done exactly 66 cycles after ld; O=2, Err=0; with the macro, Q=14.
- WIDTH=64, A=5, B=0 -> Done 2 cycles after ld; Err=1, O=5; Q=all ones with the macro.
- WIDTH=8, A=255, B=255 -> O=0 after 10 cycles. Then A=3, B=200 -> O=3, and Err stays 0.
- Busy-phase ld: issue ld with A=1000, B=13. Pulse ld with A=9, B=4 at cycle 5 -> ignored; the result is O=12 and only one Done occurs.
- ld held high continuously with A=17, B=5, WIDTH=8 -> back-to-back Done pulses every 11 cycles, each with O=2.
- rst driven low at cycle 20 of a WIDTH=64 operation -> all outputs 0 immediately and no Done. After release, a fresh ld with A=2^63+1, B=3 gives O=0.

Source files
------------

// File: rtl/modulo_pkg.sv
// Shared types and helpers for the fixed-latency restoring modulo unit.
package modulo_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    FIN  = 2'd2,
    ZERO = 2'd3
  } mod_state_t;

  // Counter must hold WIDTH-1; keep at least one bit for degenerate widths.
  function automatic int cnt_width(input int w);
    return (w > 1) ? $clog2(w) : 1;
  endfunction

endpackage

// File: rtl/mod_sub_stage.sv
// One restoring step: subtract the modulus from the shifted partial remainder when it fits.
module mod_sub_stage #(
  parameter int WIDTH = 64
) (
  input  logic [WIDTH:0]   t,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH:0]   r,
  output logic             qbit
);

  logic [WIDTH:0] bx;

  assign bx   = {1'b0, b};
  assign qbit = (t >= bx);
  assign r    = qbit ? (t - bx) : t;

endmodule

// File: rtl/modulo_seq.sv
// Radix-2 restoring modulo, WIDTH+2 cycles per nonzero modulus, with busy and divide-by-zero flags.
// Define MODULO_QUOTIENT_EN to expose the quotient on Q.
module modulo_seq
  import modulo_pkg::*;
#(
  parameter int WIDTH = 64,
  parameter int CNT_W = cnt_width(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             ld,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic [WIDTH-1:0] O,
  output logic             Done,
  output logic             Busy,
  output logic             Err
`ifdef MODULO_QUOTIENT_EN
  ,
  output logic [WIDTH-1:0] Q
`endif
);

  mod_state_t       state;
  logic [WIDTH-1:0] a_sh;
  logic [WIDTH-1:0] b_r;
  logic [WIDTH:0]   rem;
  logic [CNT_W-1:0] cnt;

  logic [WIDTH:0]   t;
  logic [WIDTH:0]   r;
  logic             qbit;
  logic             q_in;
  logic             rem_msb_unused;

  assign t              = {rem[WIDTH-1:0], a_sh[WIDTH-1]};
  assign rem_msb_unused = rem[WIDTH];

  mod_sub_stage #(.WIDTH(WIDTH)) u_sub (
    .t    (t),
    .b    (b_r),
    .r    (r),
    .qbit (qbit)
  );

`ifdef MODULO_QUOTIENT_EN
  assign q_in = qbit;
`else
  logic qbit_unused;
  assign qbit_unused = qbit;
  assign q_in        = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
      a_sh  <= '0;
      b_r   <= '0;
      rem   <= '0;
      cnt   <= '0;
      O     <= '0;
      Done  <= 1'b0;
      Busy  <= 1'b0;
      Err   <= 1'b0;
`ifdef MODULO_QUOTIENT_EN
      Q     <= '0;
`endif
    end else begin
      Done <= 1'b0;
      case (state)
        IDLE: begin
          Busy <= 1'b0;
          // The Done cycle still sits in IDLE; a held ld is taken one cycle later.
          if (ld && !Done) begin
            Busy  <= 1'b1;
            Err   <= 1'b0;
            a_sh  <= A;
            b_r   <= B;
            rem   <= '0;
            cnt   <= CNT_W'(WIDTH - 1);
            state <= (B == '0) ? ZERO : RUN;
          end
        end
        RUN: begin
          rem  <= r;
          a_sh <= {a_sh[WIDTH-2:0], q_in};
          if (cnt == '0) state <= FIN;
          else           cnt   <= cnt - CNT_W'(1);
        end
        FIN: begin
          O     <= rem[WIDTH-1:0];
          Done  <= 1'b1;
          Err   <= 1'b0;
          state <= IDLE;
`ifdef MODULO_QUOTIENT_EN
          Q     <= a_sh;
`endif
        end
        ZERO: begin
          O     <= a_sh;
          Done  <= 1'b1;
          Err   <= 1'b1;
          state <= IDLE;
`ifdef MODULO_QUOTIENT_EN
          Q     <= '1;
`endif
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
